copy_engine: RTL and testbench
==============================

Name: copy_engine

Overview:
Memory-to-memory word copy engine. On a `start` pulse it latches the source address, destination address and word count. It then moves the words one at a time over a single shared memory port: read one word, then write it. It sits between a control master and a single-port memory or bus slave. When finished, `done` stays high until the next accepted start.

Parameters:
ADDR_W, 32, address width (byte addresses)
DATA_W, 32, data word width; address stride per word = DATA_W/8
LEN_W, 16, width of the word-count field

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; accepted only in IDLE or DONE
src_addr  in  ADDR_W  source byte address, sampled on accepted start
dst_addr  in  ADDR_W  destination byte address, sampled on accepted start
length  in  LEN_W  number of words to copy, sampled on accepted start
done  out  1  high from completion until the next accepted start
busy  out  1  high while a copy is in progress (states RD, WR)
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_W  transaction byte address
mem_wdata  out  DATA_W  write data, valid while mem_req && mem_we
mem_rdata  in  DATA_W  read data, valid in the cycle mem_ready is high for a read
mem_ready  in  1  the transaction completes in any cycle where mem_req && mem_ready

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high (`rst`, sampled on the rising edge of `clk`).
- Reset values: state=IDLE; done, busy, mem_req, mem_we = 0; mem_addr, mem_wdata and internal counters = 0.
- Reset mid-operation: the transfer is abandoned, nothing is resumed, all outputs return to reset values on the next edge.
- States: IDLE, RD, WR, DONE. All outputs are registered, or decoded directly from the state and registers.
- IDLE/DONE with start=1:
  - latch src, dst and remaining=length; clear done.
  - If length==0, go to DONE (done=1 one cycle after start).
  - Otherwise go to RD.
- RD: mem_req=1, mem_we=0, mem_addr=src_ptr. On mem_ready, capture mem_rdata into the data buffer and go to WR.
- WR: mem_req=1, mem_we=1, mem_addr=dst_ptr, mem_wdata=buffer. On mem_ready:
  - src_ptr += DATA_W/8, dst_ptr += DATA_W/8, remaining -= 1.
  - If remaining was 1, go to DONE; otherwise go to RD.
- While mem_ready=0, mem_req, mem_we, mem_addr and mem_wdata hold stable (no request withdrawal).
- DONE: done=1, busy=0, mem_req=0; state held until the next start.
- start while busy is ignored; in-flight parameters are unaffected.
- Pointer arithmetic is modulo 2^ADDR_W; wrap-around past the top address is silent.
- Addresses are not alignment-checked. Low address bits pass through unchanged.
- Minimum latency with mem_ready tied high: N words take 2N cycles from start acceptance to done=1.
- Source and destination ranges are independent. Overlap is not detected and is copied in ascending address order.

Optional Feature:
- Macro: COPY_ENGINE_PERF_EN.
- When defined:
  - adds output `cycle_count`, 32 bits.
  - Cleared on an accepted start.
  - Increments every cycle while busy=1; holds its value in DONE and IDLE.
  - Resets to 0.
  - Saturates at all-ones.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package copy_engine_pkg:
  - state enum (IDLE, RD, WR, DONE)
  - default width constants (ADDR_W, DATA_W, LEN_W)
  - word-stride constant, DATA_W/8
- No sub-module required. The optional perf counter may be a small sub-module, copy_engine_perf_cnt.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> done=0, busy=0, mem_req=0.
- Basic copy: src=0x1000, dst=0x2000, length=4, mem_ready=1, memory preloaded 0xA0..0xA3.
  - Required reads: 0x1000, 0x1004, 0x1008, 0x100C.
  - Required writes to 0x2000..0x200C with the same data.
  - done=1 8 cycles after start; memory at 0x2000..0x200C equals 0xA0..0xA3.
- Zero length: start with length=0 -> no mem_req ever; done=1 on the cycle after start.
- Wait states: mem_ready high only every 3rd cycle, length=2 -> request fields stable while stalled; correct data copied; done asserted.
- Busy-ignore and restart:
  - Pulse start with new parameters mid-copy -> ignored.
  - After done, start src=0xFFFFFFFC, length=2 -> the second read address wraps to 0x00000000; done clears on that accepted start.
- Reset mid-copy: assert rst during WR of word 2 of 4 -> next cycle IDLE, mem_req=0, done=0. A subsequent copy completes normally.

Source files
------------

// File: rtl/copy_engine_pkg.sv
// Shared types and default widths for the copy engine.
package copy_engine_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_STRIDE = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Byte distance between consecutive words.
  function automatic int word_stride(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/copy_engine_perf_cnt.sv
// Saturating busy-cycle counter; cleared on accepted start (COPY_ENGINE_PERF_EN builds only).
module copy_engine_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        busy_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (busy_i && (count_q != '1)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/copy_engine.sv
// Word-by-word memory copy over one shared request/ready port (read, then write).
// Optional busy-cycle counter output enabled by defining COPY_ENGINE_PERF_EN.
module copy_engine
  import copy_engine_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
`ifdef COPY_ENGINE_PERF_EN
  output logic [31:0]       cycle_count,
`endif
  output state_e            dbg_state_o
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(word_stride(DATA_W));

  // Handshake: a transaction completes on any rising edge where mem_req && mem_ready;
  // until then mem_req, mem_we, mem_addr and mem_wdata are held stable.

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              start_ok;

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = length;
          state_d = (length == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          buf_d   = mem_rdata;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (mem_ready) begin
          src_d   = src_q + STRIDE;
          dst_d   = dst_q + STRIDE;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

  // Every output is a pure decode of registered state.
  assign busy        = (state_q == ST_RD) || (state_q == ST_WR);
  assign done        = (state_q == ST_DONE);
  assign mem_req     = busy;
  assign mem_we      = (state_q == ST_WR);
  assign mem_addr    = (state_q == ST_WR) ? dst_q : ((state_q == ST_RD) ? src_q : '0);
  assign mem_wdata   = buf_q;
  assign dbg_state_o = state_q;

`ifdef COPY_ENGINE_PERF_EN
  copy_engine_perf_cnt u_perf_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (start_ok),
    .busy_i  (busy),
    .count_o (cycle_count)
  );
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_copy_engine.sv
// Directed + randomized bench for copy_engine with a memory model and transaction scoreboard.
module tb_copy_engine;
  import copy_engine_pkg::*;

  localparam int TW = 65;  // {we, addr[31:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic        done, busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b1;
  logic [1:0]  dbg_state;
`ifdef COPY_ENGINE_PERF_EN
  logic [31:0] cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] sim_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [TW-1:0] exp_q[$];

  int ready_mode = 0;  // 0: always ready, 1: every 3rd cycle, 2: random
  int cyc = 0;

  copy_engine dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .done        (done),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
`ifdef COPY_ENGINE_PERF_EN
    .cycle_count (cycle_count),
`endif
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sim_rd(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    sim_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // memory responder + scoreboard, evaluated at the negedge before the completing edge
  logic        stall_prev = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;
  always @(negedge clk) begin
    logic [TW-1:0] obs;
    cyc++;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (cyc % 3 == 0);
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
    if (stall_prev && !rst) begin
      check("hold_req", TW'(mem_req), TW'(1'b1));
      check("hold_fields", {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0},
            {prev_we, prev_addr, prev_we ? prev_wdata : 32'h0});
    end
    mem_rdata = sim_rd(mem_addr);
    if (mem_req === 1'b1 && mem_ready) begin
      obs = {mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata};
      if (exp_q.size() == 0) begin
        check("unexpected_txn", obs, '0);
      end else begin
        check("txn", obs, exp_q.pop_front());
      end
      if (mem_we) sim_mem[mem_addr] = mem_wdata;
    end
    stall_prev = (mem_req === 1'b1) && !mem_ready;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  // driver: one copy, reference transactions built from the word-by-word rule
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int exp_lat, input int poke_at);
    int lat;
    for (int i = 0; i < int'(n); i++) begin
      logic [31:0] a, b, v;
      a = s + 32'(i * 4);
      b = d + 32'(i * 4);
      v = ref_rd(a);
      exp_q.push_back({1'b0, a, v});
      exp_q.push_back({1'b1, b, v});
      ref_mem[b] = v;
    end
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat   = 0;
    check("done_after_start", TW'(done), TW'(n == 0));
    check("busy_after_start", TW'(busy), TW'(n != 0));
    while (!done && lat < 2000) begin
      if (lat == poke_at) begin
        src_addr = 32'h5555_0000;
        dst_addr = 32'h6666_0000;
        length   = 16'd7;
        start    = 1'b1;
      end
      step();
      start = 1'b0;
      lat++;
    end
    check("done_reached", TW'(done), TW'(1'b1));
    if (exp_lat >= 0) check("latency", TW'(lat), TW'(exp_lat));
    check("scoreboard_empty", TW'(exp_q.size()), TW'(0));
    check("idle_req", {busy, mem_req}, '0);
`ifdef COPY_ENGINE_PERF_EN
    check("cycle_count", TW'(cycle_count), TW'(lat));
`endif
    for (int i = 0; i < int'(n); i++) begin
      logic [31:0] b;
      b = d + 32'(i * 4);
      check("dst_word", TW'(sim_rd(b)), TW'(ref_rd(b)));
    end
  endtask

  initial begin
    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_done", TW'(done), '0);
    check("rst_busy", TW'(busy), '0);
    check("rst_req", TW'(mem_req), '0);
    check("rst_addr", TW'(mem_addr), '0);
    check("rst_state", TW'(dbg_state), TW'(ST_IDLE));
`ifdef COPY_ENGINE_PERF_EN
    check("rst_count", TW'(cycle_count), '0);
`endif

    // basic copy
    for (int i = 0; i < 4; i++) preload(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i));
    run_copy(32'h1000, 32'h2000, 16'd4, 8, -1);
    for (int i = 0; i < 4; i++)
      check("basic_data", TW'(sim_rd(32'h2000 + 32'(i * 4))), TW'(32'hA0 + 32'(i)));

    // zero length
    run_copy(32'h3000, 32'h3100, 16'd0, 0, -1);

    // wait states
    ready_mode = 1;
    preload(32'h4000, 32'hDEAD_0001);
    preload(32'h4004, 32'hDEAD_0002);
    run_copy(32'h4000, 32'h5000, 16'd2, -1, -1);

    // randomized copies with random ready, including overlapping ranges
    ready_mode = 2;
    for (int t = 0; t < 6; t++) begin
      logic [31:0] s, d;
      int n;
      n = $urandom_range(1, 6);
      s = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 4;
      d = (t == 5) ? s + 32'd4 : 32'h0002_0000 + 32'($urandom_range(0, 255)) * 4 + 32'(t % 2);
      for (int i = 0; i < n; i++) preload(s + 32'(i * 4), $urandom);
      run_copy(s, d, 16'(n), -1, -1);
    end

    // start while busy is ignored
    ready_mode = 0;
    for (int i = 0; i < 4; i++) preload(32'h7000 + 32'(i * 4), 32'hB0 + 32'(i));
    run_copy(32'h7000, 32'h7100, 16'd4, 8, 3);

    // restart after done with address wrap
    preload(32'hFFFF_FFFC, 32'hC0C0_0001);
    preload(32'h0000_0000, 32'hC0C0_0002);
    run_copy(32'hFFFF_FFFC, 32'h6000, 16'd2, 4, -1);

    // reset during WR of the second word
    for (int i = 0; i < 4; i++) preload(32'h8000 + 32'(i * 4), 32'hE0 + 32'(i));
    src_addr = 32'h8000;
    dst_addr = 32'h8100;
    length   = 16'd4;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 32'h8000 + 32'(i * 4), 32'hE0 + 32'(i)});
      exp_q.push_back({1'b1, 32'h8100 + 32'(i * 4), 32'hE0 + 32'(i)});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("pre_rst_wr", {mem_we, mem_addr}, {1'b1, 32'h8104});
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_state", TW'(dbg_state), TW'(ST_IDLE));
    check("midrst_req", TW'(mem_req), '0);
    check("midrst_done", TW'(done), '0);
    check("midrst_busy", TW'(busy), '0);
    ref_mem[32'h8100] = sim_rd(32'h8100);
    ref_mem[32'h8104] = sim_rd(32'h8104);
    run_copy(32'h8000, 32'h8200, 16'd4, 8, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
